// File: rtl/pressure_chamber_if.sv
// Pressure chamber control bus: door status and requests in, pump/vent and status out.
interface pressure_chamber_if #(
  parameter int CNT_W = 4
);
  logic             innerClosed;
  logic             outerClosed;
  logic             pressurizeReq;
  logic             evacuateReq;
  logic             pressureChanging;
  logic             isHighPressure;
  logic             pumpOn;
  logic             ventOn;
  logic [CNT_W-1:0] countdown;
  logic             reqError;
  logic             fault;

  // Door blocks / supervisor side: drives status and requests.
  modport master (
    output innerClosed, outerClosed, pressurizeReq, evacuateReq,
    input  pressureChanging, isHighPressure, pumpOn, ventOn, countdown, reqError, fault
  );

  // Chamber controller side.
  modport slave (
    input  innerClosed, outerClosed, pressurizeReq, evacuateReq,
    output pressureChanging, isHighPressure, pumpOn, ventOn, countdown, reqError, fault
  );
endinterface

// File: rtl/pressure_chamber.sv
// Pressure chamber sequencer: moves between low and high pressure on request,
// timing each change with a countdown and latching a fault if a door opens mid-change.
module pressure_chamber #(
  parameter int PRESS_CYCLES = 5,
  parameter int EVAC_CYCLES  = 7,
  parameter int CNT_W        = 4
) (
  input  logic              clock,
  input  logic              reset,
  pressure_chamber_if.slave bus
);

  localparam logic [2:0] LOW_IDLE     = 3'd0;
  localparam logic [2:0] PRESSURIZING = 3'd1;
  localparam logic [2:0] HIGH_IDLE    = 3'd2;
  localparam logic [2:0] EVACUATING   = 3'd3;
  localparam logic [2:0] FAULT        = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] EVAC_LOAD  = CNT_W'(EVAC_CYCLES - 1);

  logic [2:0]       state_r;
  logic [2:0]       state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             err_r;
  logic             err_s;
  logic             doors_ok_s;
  logic             any_req_s;

  assign doors_ok_s = bus.innerClosed & bus.outerClosed;
  assign any_req_s  = bus.pressurizeReq | bus.evacuateReq;

  // Next-state, countdown and request-rejection decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    err_s   = 1'b0;
    case (state_r)
      LOW_IDLE: begin
        cnt_s = CNT_ZERO;
        if (any_req_s && !doors_ok_s) begin
          err_s = 1'b1;
        end else if (bus.pressurizeReq) begin
          // pressurize wins when both requests are present
          state_s = PRESSURIZING;
          cnt_s   = PRESS_LOAD;
        end else if (bus.evacuateReq) begin
          err_s = 1'b1;
        end else begin
          err_s = 1'b0;
        end
      end
      HIGH_IDLE: begin
        cnt_s = CNT_ZERO;
        if (any_req_s && !doors_ok_s) begin
          err_s = 1'b1;
        end else if (bus.evacuateReq) begin
          // evacuate wins when both requests are present
          state_s = EVACUATING;
          cnt_s   = EVAC_LOAD;
        end else if (bus.pressurizeReq) begin
          err_s = 1'b1;
        end else begin
          err_s = 1'b0;
        end
      end
      PRESSURIZING, EVACUATING: begin
        err_s = any_req_s;
        // a door opening takes priority over a countdown that just expired
        if (!doors_ok_s) begin
          state_s = FAULT;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_ZERO) begin
          state_s = (state_r == PRESSURIZING) ? HIGH_IDLE : LOW_IDLE;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      FAULT: begin
        err_s = any_req_s;
        cnt_s = CNT_ZERO;
      end
      default: begin
        // an illegal encoding is treated as a fault condition
        state_s = FAULT;
        cnt_s   = CNT_ZERO;
        err_s   = 1'b0;
      end
    endcase
  end

  // State, countdown and error-pulse registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= LOW_IDLE;
      cnt_r   <= CNT_ZERO;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      err_r   <= err_s;
    end
  end

  assign bus.pressureChanging = (state_r == PRESSURIZING) || (state_r == EVACUATING);
  assign bus.isHighPressure   = (state_r == HIGH_IDLE) || (state_r == EVACUATING) ||
                                (state_r == FAULT);
  assign bus.pumpOn           = (state_r == PRESSURIZING);
  assign bus.ventOn           = (state_r == EVACUATING);
  assign bus.fault            = (state_r == FAULT);
  assign bus.countdown        = cnt_r;
  assign bus.reqError         = err_r;

endmodule

// File: tb/tb_pressure_chamber.sv
// Self-checking bench for pressure_chamber against a phase/elapsed-time model.
module tb_pressure_chamber;

  localparam int P = 5;
  localparam int E = 7;
  localparam int W = 4;

  // model phases
  localparam int M_LOW   = 0;
  localparam int M_PRESS = 1;
  localparam int M_HIGH  = 2;
  localparam int M_EVAC  = 3;
  localparam int M_FAULT = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pressure_chamber_if #(.CNT_W(W)) bus ();

  pressure_chamber #(.PRESS_CYCLES(P), .EVAC_CYCLES(E), .CNT_W(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  int m_mode = M_LOW;
  int m_done = 0;   // pressure-changing cycles already elapsed in current change
  bit m_err  = 1'b0;

  // Model: advance one clock edge given the inputs sampled on that edge.
  task automatic model_step(input bit r, input bit ic, input bit oc, input bit pr, input bit ev);
    bit closed;
    int total;
    closed = ic && oc;
    if (r) begin
      m_mode = M_LOW; m_done = 0; m_err = 1'b0;
      return;
    end
    if (m_mode == M_LOW || m_mode == M_HIGH) begin
      bool_idle(closed, pr, ev);
    end else if (m_mode == M_FAULT) begin
      m_err = pr || ev;
    end else begin
      m_err = pr || ev;
      total = (m_mode == M_PRESS) ? P : E;
      if (!closed) begin
        m_mode = M_FAULT; m_done = 0;
      end else if (m_done + 1 == total) begin
        m_mode = (m_mode == M_PRESS) ? M_HIGH : M_LOW; m_done = 0;
      end else begin
        m_done = m_done + 1;
      end
    end
  endtask

  // Model: request handling while resting at low or high pressure.
  task automatic bool_idle(input bit closed, input bit pr, input bit ev);
    bit wanted;
    bit other;
    wanted = (m_mode == M_LOW) ? pr : ev;
    other  = (m_mode == M_LOW) ? ev : pr;
    m_err = 1'b0;
    if ((pr || ev) && !closed) m_err = 1'b1;
    else if (wanted) begin
      m_mode = (m_mode == M_LOW) ? M_PRESS : M_EVAC;
      m_done = 0;
    end else if (other) m_err = 1'b1;
  endtask

  function automatic logic [W+5:0] exp_vec();
    bit changing;
    bit high;
    int total;
    logic [W-1:0] cd;
    changing = (m_mode == M_PRESS) || (m_mode == M_EVAC);
    high     = (m_mode == M_HIGH) || (m_mode == M_EVAC) || (m_mode == M_FAULT);
    total    = (m_mode == M_PRESS) ? P : E;
    cd       = changing ? W'(total - 1 - m_done) : '0;
    return {(m_mode == M_FAULT), m_err, changing, high,
            (m_mode == M_PRESS), (m_mode == M_EVAC), cd};
  endfunction

  function automatic logic [W+5:0] obs_vec();
    return {bus.fault, bus.reqError, bus.pressureChanging, bus.isHighPressure,
            bus.pumpOn, bus.ventOn, bus.countdown};
  endfunction

  // Drive inputs, update the model for the coming edge, then settle to the falling edge.
  task automatic tick(input bit r, input bit ic, input bit oc, input bit pr, input bit ev);
    reset             = r;
    bus.innerClosed   = ic;
    bus.outerClosed   = oc;
    bus.pressurizeReq = pr;
    bus.evacuateReq   = ev;
    model_step(r, ic, oc, pr, ev);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    n_total++;
    if (obs_vec() !== exp_vec()) $display("FAIL reset_model: got %h expected %h", obs_vec(), exp_vec());
    else n_pass++;
    n_total++;
    if (obs_vec() !== '0) $display("FAIL reset_zero: got %h expected 0", obs_vec());
    else n_pass++;
  endtask

  task automatic test_pressurize();
    int pumps;
    pumps = 0;
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < P + 1; i++) begin
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL pressurize_cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else n_pass++;
      if (bus.pumpOn === 1'b1) pumps++;
      tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    n_total++;
    if (pumps !== P || bus.isHighPressure !== 1'b1)
      $display("FAIL pressurize_len: got pumps=%0d high=%b expected pumps=%0d high=1", pumps, bus.isHighPressure, P);
    else n_pass++;
  endtask

  task automatic test_evacuate();
    int vents;
    vents = 0;
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < E + 1; i++) begin
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL evacuate_cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else n_pass++;
      if (bus.ventOn === 1'b1) vents++;
      tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    n_total++;
    if (vents !== E || bus.isHighPressure !== 1'b0)
      $display("FAIL evacuate_len: got vents=%0d high=%b expected vents=%0d high=0", vents, bus.isHighPressure, E);
    else n_pass++;
  endtask

  task automatic test_req_errors();
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);   // outer door open
    n_total++;
    if (bus.reqError !== 1'b1 || bus.pumpOn !== 1'b0 || obs_vec() !== exp_vec())
      $display("FAIL err_door_open: got %h expected %h", obs_vec(), exp_vec());
    else n_pass++;
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_total++;
    if (obs_vec() !== exp_vec()) $display("FAIL err_clears: got %h expected %h", obs_vec(), exp_vec());
    else n_pass++;
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);   // evacuate while already low
    n_total++;
    if (bus.reqError !== 1'b1 || obs_vec() !== exp_vec())
      $display("FAIL err_evac_low: got %h expected %h", obs_vec(), exp_vec());
    else n_pass++;
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_fault();
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);   // countdown 4
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);   // 3
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);   // 2
    n_total++;
    if (bus.countdown !== 4'd2) $display("FAIL fault_setup: got countdown %0d expected 2", bus.countdown);
    else n_pass++;
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);   // inner door drops
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (bus.fault !== 1'b1 || bus.pressureChanging !== 1'b0 || bus.isHighPressure !== 1'b1 ||
          obs_vec() !== exp_vec())
        $display("FAIL fault_hold%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else n_pass++;
      tick(1'b0, 1'b1, 1'b1, (i == 1), (i == 2));
    end
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    n_total++;
    if (obs_vec() !== '0) $display("FAIL fault_reset: got %h expected 0", obs_vec());
    else n_pass++;
  endtask

  task automatic test_reset_mid_evac();
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < P; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);   // 6
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_total++;
    if (bus.countdown !== 4'd3 || bus.ventOn !== 1'b1)
      $display("FAIL midevac_setup: got %h expected %h", obs_vec(), exp_vec());
    else n_pass++;
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);   // reset dominates the request
    n_total++;
    if (obs_vec() !== '0) $display("FAIL midevac_reset: got %h expected 0", obs_vec());
    else n_pass++;
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    n_total++;
    if (bus.pumpOn !== 1'b1 || bus.countdown !== 4'd4 || obs_vec() !== exp_vec())
      $display("FAIL midevac_repress: got %h expected %h", obs_vec(), exp_vec());
    else n_pass++;
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_both_requests();
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    n_total++;
    if (bus.pumpOn !== 1'b1 || bus.reqError !== 1'b0 || obs_vec() !== exp_vec())
      $display("FAIL both_low: got %h expected %h", obs_vec(), exp_vec());
    else n_pass++;
    for (int i = 0; i < P + 3; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);   // pressurize held throughout
      n_total++;
      if (bus.reqError !== 1'b1 || obs_vec() !== exp_vec())
        $display("FAIL held_press%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_total++;
    if (bus.isHighPressure !== 1'b1 || bus.pressureChanging !== 1'b0)
      $display("FAIL held_no_retrigger: got %h expected %h", obs_vec(), exp_vec());
    else n_pass++;
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    n_total++;
    if (bus.ventOn !== 1'b1 || bus.reqError !== 1'b0 || obs_vec() !== exp_vec())
      $display("FAIL both_high: got %h expected %h", obs_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_random();
    bit r, ic, oc, pr, ev;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) < 3);
      ic = ($urandom_range(0, 99) < 96);
      oc = ($urandom_range(0, 99) < 96);
      pr = ($urandom_range(0, 99) < 25);
      ev = ($urandom_range(0, 99) < 25);
      tick(r, ic, oc, pr, ev);
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL random_%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    bus.innerClosed   = 1'b1;
    bus.outerClosed   = 1'b1;
    bus.pressurizeReq = 1'b0;
    bus.evacuateReq   = 1'b0;
    test_reset();
    test_pressurize();
    test_evacuate();
    test_req_errors();
    test_fault();
    test_reset_mid_evac();
    test_both_requests();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
